// File: rtl/block_tx_gearbox_if.sv
// Encoder-side and PMA-side handshake bundle for the 66b->64b TX gearbox.
// Signal names are seen from the gearbox: i_* flow in, o_* flow out.
interface block_tx_gearbox_if #(
    parameter int NB_CODED_BLOCK = 66,
    parameter int NB_DATA_OUT    = NB_CODED_BLOCK - 2
);
    logic                      i_valid;
    logic [NB_CODED_BLOCK-1:0] i_data;
    logic                      i_sh_corrupt;
    logic                      o_ready;
    logic                      o_valid;
    logic [NB_DATA_OUT-1:0]    o_data;

    modport slave (
        input  i_valid, i_data, i_sh_corrupt,
        output o_ready, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, i_sh_corrupt,
        input  o_ready, o_valid, o_data
    );
endinterface

// File: rtl/block_tx_gearbox.sv
// Packs 66-bit coded blocks into a continuous 64-bit word stream, MSB first.
// Every 33rd cycle drains the 64-bit residue while the encoder is held off.
module block_tx_gearbox #(
    parameter int NB_CODED_BLOCK = 66,
    parameter int NB_DATA_OUT    = NB_CODED_BLOCK - 2,
    parameter int N_PHASES       = NB_DATA_OUT / 2 + 1,
    parameter int NB_RESIDUE     = $clog2(NB_DATA_OUT + 1)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    block_tx_gearbox_if.slave       bus
);
    localparam int NB_COMB = NB_DATA_OUT + NB_CODED_BLOCK;
    localparam logic [NB_RESIDUE-1:0] R_FULL = NB_RESIDUE'(2 * (N_PHASES - 1));

    logic [NB_RESIDUE-1:0]     res_cnt_q, res_cnt_d;
    logic [NB_DATA_OUT-1:0]    res_buf_q, res_buf_d;
    logic [NB_DATA_OUT-1:0]    o_data_q, o_data_d;
    logic                      o_valid_q, o_valid_d;

    logic [NB_CODED_BLOCK-1:0] blk;
    logic [NB_COMB-1:0]        comb;
    logic [NB_RESIDUE:0]       shift_amt;
    logic [NB_CODED_BLOCK-1:0] keep_mask;

    // Residue is kept right-aligned with zeros above its R valid bits, so
    // {residue, block} holds the pending stream in its low R+66 bits.
    always_comb begin
        blk       = bus.i_sh_corrupt ? {2'b00, bus.i_data[NB_DATA_OUT-1:0]} : bus.i_data;
        comb      = {res_buf_q, blk};
        shift_amt = {1'b0, res_cnt_q} + (NB_RESIDUE + 1)'(2);
        keep_mask = ~({NB_CODED_BLOCK{1'b1}} << shift_amt);
    end

    always_comb begin
        res_cnt_d = res_cnt_q;
        res_buf_d = res_buf_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        if (i_enable) begin
            if (res_cnt_q == R_FULL) begin
                o_data_d  = res_buf_q;
                res_buf_d = '0;
                res_cnt_d = '0;
                o_valid_d = 1'b1;
            end else if (bus.i_valid) begin
                // Top 64 bits of the stream leave now; the block's low R+2 bits stay.
                o_data_d  = NB_DATA_OUT'(comb >> shift_amt);
                res_buf_d = NB_DATA_OUT'(blk & keep_mask);
                res_cnt_d = res_cnt_q + NB_RESIDUE'(2);
                o_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            res_cnt_q <= '0;
            res_buf_q <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            res_cnt_q <= res_cnt_d;
            res_buf_q <= res_buf_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Gated by reset so the encoder is never told "ready" while reset is held.
    assign bus.o_ready = i_enable && i_reset && (res_cnt_q != R_FULL);
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
endmodule

// File: tb/tb_block_tx_gearbox.sv
// Randomised and directed bench for block_tx_gearbox against a bit-queue model
// of the serial stream: accepted blocks append 66 bits, every word removes 64.
module tb_block_tx_gearbox;
    localparam int NB_CB = 66;
    localparam int NB_DO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    block_tx_gearbox_if #(.NB_CODED_BLOCK(NB_CB)) bus();

    block_tx_gearbox #(.NB_CODED_BLOCK(NB_CB)) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .i_enable (en),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_words  = 0;

    bit               model_q[$];
    logic             exp_valid = 1'b0;
    logic [NB_DO-1:0] exp_data  = '0;

    task automatic chk(input string tag, input logic [NB_CB-1:0] obs, input logic [NB_CB-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs at negedge, check ready, advance model, check outputs at next negedge.
    task automatic step(input logic rst, input logic e, input logic v,
                        input logic [NB_CB-1:0] d, input logic c);
        logic [NB_CB-1:0] blk;
        logic             exp_ready;
        rst_n            = rst;
        en               = e;
        bus.i_valid      = v;
        bus.i_data       = d;
        bus.i_sh_corrupt = c;
        #1;
        exp_ready = rst && e && (model_q.size() != NB_DO);
        chk("o_ready", NB_CB'(bus.o_ready), NB_CB'(exp_ready));
        if (!rst) begin
            model_q.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
        end else if (!e) begin
            exp_valid = 1'b0;
        end else if (model_q.size() == NB_DO) begin
            for (int i = NB_DO - 1; i >= 0; i--) exp_data[i] = model_q.pop_front();
            exp_valid = 1'b1;
        end else if (v) begin
            blk = c ? {2'b00, d[NB_DO-1:0]} : d;
            for (int i = NB_CB - 1; i >= 0; i--) model_q.push_back(blk[i]);
            for (int i = NB_DO - 1; i >= 0; i--) exp_data[i] = model_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("o_valid", NB_CB'(bus.o_valid), NB_CB'(exp_valid));
        chk("o_data", NB_CB'(bus.o_data), NB_CB'(exp_data));
        if (bus.o_valid) begin
            $display("word %0d: o_data=%h queued_bits=%0d", n_words, bus.o_data, model_q.size());
            n_words++;
        end
    endtask

    function automatic logic [NB_CB-1:0] rand_block();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[NB_CB-1:0];
    endfunction

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.i_valid      = 1'b0;
        bus.i_data       = '0;
        bus.i_sh_corrupt = 1'b0;
        @(negedge clk);

        // Reset, release idle: ready high, no word, zero data.
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("post_reset_data", NB_CB'(bus.o_data), '0);

        // Known-answer pair.
        step(1'b1, 1'b1, 1'b1, {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0);
        chk("kat_word0", NB_CB'(bus.o_data), NB_CB'(64'hBFFF_FFFF_FFFF_FFFF));
        step(1'b1, 1'b1, 1'b1, {2'b01, 64'h0}, 1'b0);
        chk("kat_word1", NB_CB'(bus.o_data), NB_CB'({2'b11, 2'b01, 60'h0}));

        // Full period of continuous blocks: 32 accepts then one stall.
        do_reset();
        for (int k = 0; k < 33; k++) begin
            logic [3:0] nib;
            nib = 4'(k);
            step(1'b1, 1'b1, 1'b1, {2'b01, {16{nib}}}, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, {2'b10, 64'h0123_4567_89AB_CDEF}, 1'b0);
        chk("period_restart_hdr", NB_CB'(bus.o_data[63:62]), NB_CB'(2'b10));

        // Idle gap of 3 cycles at R=20, then finish the period.
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1, rand_block(), 1'b0);
        for (int k = 0; k < 3; k++)  step(1'b1, 1'b1, 1'b0, rand_block(), 1'b0);
        for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b1, rand_block(), 1'b0);

        // Header corruption on block 5 of a period.
        do_reset();
        for (int k = 0; k < 33; k++) begin
            step(1'b1, 1'b1, 1'b1, {2'b10, 32'hA5A5_5A5A, $urandom}, (k == 5));
            if (k == 5) chk("sh_corrupt_hdr", NB_CB'(bus.o_data[53:52]), '0);
        end

        // Reset at R=40, then a fresh period.
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b1, rand_block(), 1'b0);
        do_reset();
        chk("midreset_data", NB_CB'(bus.o_data), '0);
        step(1'b1, 1'b1, 1'b1, {2'b10, 64'h0F0F_0F0F_0F0F_0F0F}, 1'b0);
        chk("midreset_hdr", NB_CB'(bus.o_data[63:62]), NB_CB'(2'b10));
        for (int k = 0; k < 33; k++) step(1'b1, 1'b1, 1'b1, rand_block(), 1'b0);

        // Random traffic with enable gaps, idles, corruption and occasional reset.
        for (int k = 0; k < 700; k++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 4) != 0), rand_block(), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
